// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared types and constants for the pipeline hazard controller (register index type, pipeline-register control bundle, default mul/div latency)
package hazard_ctrl_pkg;
  localparam int MULDIV_LAT = 4;
  typedef logic [4:0] creg_addr_t;
  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic flush_d;
    logic flush_e;
  } hazard_ctrl_t;
endpackage

// File: rtl/hazard_ctrl_scoreboard.sv
// hazard_ctrl_scoreboard: pending-write scoreboard with set-priority update and write-through ready lookups; ports: clk/reset, set_en/set_rd, wb_valid/wb_wen/wb_rd, lookup ra1/ra2/rd -> pend1/pend2/pend_rd, sb
module hazard_ctrl_scoreboard
  import hazard_ctrl_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            set_en,
  input  creg_addr_t      set_rd,
  input  logic            wb_valid,
  input  logic            wb_wen,
  input  creg_addr_t      wb_rd,
  input  creg_addr_t      ra1,
  input  creg_addr_t      ra2,
  input  creg_addr_t      rd,
  output logic            pend1,
  output logic            pend2,
  output logic            pend_rd,
  output logic [NREG-1:0] sb
);
  logic [NREG-1:0] sb_q, sb_d, set_m, clr_m;
  logic wb_hit;
  function automatic logic wbclr(creg_addr_t r);
    return wb_hit & (wb_rd == r);
  endfunction
  assign wb_hit = wb_valid & wb_wen & (wb_rd != '0);
  assign set_m = (set_en & (set_rd != '0)) ? NREG'(1) << set_rd : '0;
  assign clr_m = wb_hit ? NREG'(1) << wb_rd : '0;
  // a register retiring this cycle is already visible through the write-through regfile
  assign pend1 = sb_q[ra1] & ~wbclr(ra1);
  assign pend2 = sb_q[ra2] & ~wbclr(ra2);
  assign pend_rd = sb_q[rd] & ~wbclr(rd);
  assign sb = sb_q;
  always_comb begin
    sb_d = (sb_q & ~clr_m) | set_m;
    sb_d[0] = 1'b0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) sb_q <= '0;
    else sb_q <= sb_d;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: issue/stall/flush controller; ports: decode operands, writeback retire, redirect, imem/dmem wait in; issue, stall_f/d, flush_d/e, ex_busy, sb_pending out
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int NREG = 32,
  parameter int MULDIV_LAT = hazard_ctrl_pkg::MULDIV_LAT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            d_valid,
  input  creg_addr_t      d_ra1,
  input  logic            d_use1,
  input  creg_addr_t      d_ra2,
  input  logic            d_use2,
  input  creg_addr_t      d_rd,
  input  logic            d_wen,
  input  logic            d_multi,
  input  logic            wb_valid,
  input  creg_addr_t      wb_rd,
  input  logic            wb_wen,
  input  logic            redirect,
  input  logic            imem_wait,
  input  logic            dmem_wait,
  output logic            issue,
  output logic            stall_f,
  output logic            stall_d,
  output logic            flush_d,
  output logic            flush_e,
  output logic            ex_busy,
  output logic [NREG-1:0] sb_pending
);
  localparam int CW = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic pend1, pend2, pend_rd, raw, waw, go, hold;
  hazard_ctrl_t ctl;
  hazard_ctrl_scoreboard #(.NREG(NREG)) u_sb (
    .clk(clk), .reset(reset),
    .set_en(go & d_wen), .set_rd(d_rd),
    .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_rd(wb_rd),
    .ra1(d_ra1), .ra2(d_ra2), .rd(d_rd),
    .pend1(pend1), .pend2(pend2), .pend_rd(pend_rd),
    .sb(sb_pending)
  );
  assign raw = d_valid & ((d_use1 & pend1) | (d_use2 & pend2));
  assign waw = d_valid & d_wen & (d_rd != '0) & pend_rd;
  assign ex_busy = cnt_q != '0;
  assign go = d_valid & ~raw & ~waw & ~ex_busy & ~dmem_wait & ~redirect;
  assign hold = d_valid & ~go;
  assign issue = go & ~reset;
  // reset forces bubbles into both pipeline registers
  always_comb begin
    ctl = reset     ? '{1'b0, 1'b0, 1'b1, 1'b1} :
          dmem_wait ? '{1'b1, 1'b1, 1'b0, 1'b0} :
          redirect  ? '{imem_wait, 1'b0, 1'b1, 1'b1} :
                      '{hold | imem_wait, hold, imem_wait & ~hold, ~go};
    cnt_d = (go & d_multi)          ? CW'(MULDIV_LAT - 1) :
            (ex_busy & ~dmem_wait)  ? cnt_q - 1'b1 : cnt_q;
  end
  assign {stall_f, stall_d, flush_d, flush_e} = ctl;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard-queue self-checking bench for hazard_ctrl
module tb_hazard_ctrl;
  localparam int LAT = 4;
  logic clk = 1'b0, reset;
  logic d_valid, d_use1, d_use2, d_wen, d_multi, wb_valid, wb_wen, redirect, imem_wait, dmem_wait;
  logic [4:0] d_ra1, d_ra2, d_rd, wb_rd;
  logic issue, stall_f, stall_d, flush_d, flush_e, ex_busy;
  logic [31:0] sb_pending;
  logic [31:0] msb;
  int mcnt;
  int n_chk = 0, n_err = 0;
  logic [37:0] exp_q[$];

  always #5 clk = ~clk;

  hazard_ctrl #(.NREG(32), .MULDIV_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .d_valid(d_valid), .d_ra1(d_ra1), .d_use1(d_use1), .d_ra2(d_ra2), .d_use2(d_use2),
    .d_rd(d_rd), .d_wen(d_wen), .d_multi(d_multi),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_wen(wb_wen),
    .redirect(redirect), .imem_wait(imem_wait), .dmem_wait(dmem_wait),
    .issue(issue), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
    .ex_busy(ex_busy), .sb_pending(sb_pending)
  );

  task automatic check(string tag, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic mwb(logic [4:0] r);
    return wb_valid && wb_wen && wb_rd == r && r != 0;
  endfunction

  function automatic logic mhz(logic [4:0] r);
    return msb[r] && !mwb(r);
  endfunction

  // expected {issue, stall_f, stall_d, flush_d, flush_e, ex_busy, sb_pending}
  function automatic logic [37:0] model_out();
    logic raw, waw, busy, iss, sf, sd, fd, fe;
    if (reset) return {5'b00011, 1'b0, 32'h0};
    raw = d_valid && ((d_use1 && mhz(d_ra1)) || (d_use2 && mhz(d_ra2)));
    waw = d_valid && d_wen && d_rd != 0 && mhz(d_rd);
    busy = mcnt != 0;
    iss = d_valid && !raw && !waw && !busy && !dmem_wait && !redirect;
    if (dmem_wait) {sf, sd, fd, fe} = 4'b1100;
    else if (redirect) {sf, sd, fd, fe} = {imem_wait, 3'b011};
    else begin
      sd = d_valid && !iss;
      sf = sd || imem_wait;
      fe = !iss;
      fd = imem_wait && !sd;
    end
    return {iss, sf, sd, fd, fe, busy, msb};
  endfunction

  task automatic eval(string tag);
    logic [37:0] e;
    exp_q.push_back(model_out());
    #2;
    e = exp_q.pop_front();
    check(tag, {issue, stall_f, stall_d, flush_d, flush_e, ex_busy, sb_pending}, e);
  endtask

  task automatic tick();
    logic iss;
    iss = model_out() >> 37;
    if (wb_valid && wb_wen && wb_rd != 0) msb[wb_rd] = 1'b0;
    if (iss && d_wen && d_rd != 0) msb[d_rd] = 1'b1;
    if (iss && d_multi) mcnt = LAT - 1;
    else if (mcnt != 0 && !dmem_wait) mcnt--;
    @(negedge clk);
  endtask

  task automatic step(string tag);
    eval(tag);
    tick();
  endtask

  task automatic idle();
    {d_valid, d_use1, d_use2, d_wen, d_multi, wb_valid, wb_wen, redirect, imem_wait, dmem_wait} = '0;
    {d_ra1, d_ra2, d_rd, wb_rd} = '0;
  endtask

  task automatic instr(logic [4:0] rd, logic wen, logic multi, logic [4:0] ra1, logic use1);
    d_valid = 1'b1; d_rd = rd; d_wen = wen; d_multi = multi;
    d_ra1 = ra1; d_use1 = use1; d_ra2 = 5'd0; d_use2 = 1'b0;
  endtask

  task automatic wb(logic [4:0] rd);
    wb_valid = 1'b1; wb_wen = 1'b1; wb_rd = rd;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    msb = '0;
    mcnt = 0;
    @(negedge clk);
    d_valid = 1'b1;
    eval("reset");
    check("reset_flush_d", flush_d, 1);
    check("reset_issue", issue, 0);
    @(negedge clk);
    reset = 1'b0;
    idle();
    // RAW on x5 released by writeback at cycle 4
    instr(5, 1, 0, 0, 0);
    eval("raw_c0");
    check("raw_c0_iss", issue, 1);
    tick();
    for (int i = 1; i <= 3; i++) begin
      instr(0, 0, 0, 5, 1);
      eval("raw_wait");
      check("raw_wait_stall", {issue, stall_d, flush_e}, 3'b011);
      tick();
    end
    wb(5);
    eval("raw_c4");
    check("raw_c4_iss", issue, 1);
    tick();
    idle();
    eval("raw_c5");
    check("raw_c5_sb5", sb_pending[5], 0);
    tick();
    // x0 never hazards
    instr(0, 1, 0, 0, 0);
    step("x0_wr");
    instr(0, 0, 0, 0, 1);
    d_ra2 = 0; d_use2 = 1;
    eval("x0_rd");
    check("x0_rd_iss", issue, 1);
    check("x0_sb", sb_pending, 0);
    tick();
    // same-cycle set/clear on x7: set wins
    idle();
    instr(7, 1, 0, 0, 0);
    step("x7_set");
    instr(7, 1, 0, 0, 0);
    wb(7);
    eval("x7_waw");
    check("x7_waw_iss", issue, 1);
    tick();
    idle();
    eval("x7_after");
    check("x7_still", sb_pending[7], 1);
    tick();
    wb(7);
    step("x7_clr");
    idle();
    // mul/div occupancy
    instr(0, 0, 1, 0, 0);
    step("md_t");
    for (int i = 1; i < LAT; i++) begin
      instr(3, 1, 0, 0, 0);
      eval("md_busy");
      check("md_busy_flags", {ex_busy, issue, stall_d}, 3'b101);
      tick();
    end
    eval("md_next");
    check("md_next_iss", issue, 1);
    tick();
    idle();
    wb(3);
    step("md_clr");
    idle();
    // redirect over a RAW hazard
    instr(9, 1, 0, 0, 0);
    step("rd_set9");
    instr(0, 0, 0, 9, 1);
    redirect = 1;
    eval("redir");
    check("redir_flags", {flush_d, flush_e, stall_d, issue}, 4'b1100);
    check("redir_sb9", sb_pending[9], 1);
    imem_wait = 1;
    eval("redir_iw");
    check("redir_iw_sf", stall_f, 1);
    tick();
    idle();
    wb(9);
    step("rd_clr9");
    idle();
    // dmem_wait freezes the counter; late redirect honoured after release
    instr(0, 0, 1, 0, 0);
    step("dw_md");
    idle();
    step("dw_dec");
    for (int i = 0; i < 3; i++) begin
      instr(4, 1, 0, 0, 0);
      dmem_wait = 1;
      redirect = (i == 2);
      eval("dw_hold");
      check("dw_flags", {stall_f, stall_d, flush_e, issue, ex_busy}, 5'b11001);
      tick();
    end
    dmem_wait = 0;
    redirect = 1;
    eval("dw_rel");
    check("dw_rel_flags", {flush_d, flush_e, stall_d, issue, ex_busy}, 5'b11001);
    tick();
    idle();
    eval("dw_cnt1");
    check("dw_cnt1_busy", ex_busy, 1);
    tick();
    eval("dw_cnt0");
    check("dw_cnt0_busy", ex_busy, 0);
    tick();
    // async reset between edges
    instr(5, 1, 0, 0, 0);
    step("ar_x5");
    instr(7, 1, 1, 0, 0);
    step("ar_x7");
    idle();
    #1;
    check("ar_pre_sb", sb_pending, 32'hA0);
    check("ar_pre_busy", ex_busy, 1);
    reset = 1;
    #1;
    check("ar_sb", sb_pending, 0);
    check("ar_flags", {ex_busy, flush_e, flush_d, issue}, 4'b0110);
    #1;
    reset = 0;
    msb = '0;
    mcnt = 0;
    @(negedge clk);
    // random traffic against the reference model
    for (int i = 0; i < 300; i++) begin
      d_valid = $urandom_range(0, 3) != 0;
      d_ra1 = 5'($urandom_range(0, 7)); d_use1 = 1'($urandom);
      d_ra2 = 5'($urandom_range(0, 7)); d_use2 = 1'($urandom);
      d_rd = 5'($urandom_range(0, 7)); d_wen = 1'($urandom);
      d_multi = $urandom_range(0, 7) == 0;
      wb_valid = 1'($urandom); wb_wen = 1'($urandom); wb_rd = 5'($urandom_range(0, 7));
      redirect = $urandom_range(0, 9) == 0;
      imem_wait = $urandom_range(0, 4) == 0;
      dmem_wait = $urandom_range(0, 5) == 0;
      step("rand");
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
